tt_um_reemashivva_fifo: RTL and testbench
=========================================

Name: tt_um_reemashivva_fifo

Overview:
- Tiny Tapeout user tile implementing a 4-deep x 4-bit synchronous FIFO with full and empty flags on the dedicated output pins.
- Write and read sides are paced by internal clock-enable dividers (write tick, read tick) derived from the single tile clock. This emulates independent producer and consumer rates without a second clock domain.
- Sits directly under the Tiny Tapeout harness; the pin mapping is fixed by the tt_um template.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 4, number of entries; must be a power of two.
- WR_DIV, 2, write tick period in clk cycles (>=1).
- RD_DIV, 3, read tick period in clk cycles (>=1).

Ports:
- clk  in  1  tile clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  harness enable; ignored (always treated as 1).
- ui_in  in  8  [3:0] wdata, [4] wr_rq, [5] rd_rq, [7:6] unused.
- uo_out  out  8  [3:0] rdata, [4] empty, [5] full, [7:6] driven 0.
- uio_in  in  8  unused.
- uio_out  out  8  driven constant 0.
- uio_oe  out  8  driven constant 0 (all bidirectional pins are inputs).

Behaviour:
- Reset (rst_n=0, asynchronous), all registers cleared:
  - wptr=0, rptr=0, divider counters=0, rdata=0.
  - Memory contents need no reset.
  - Outputs during and after reset: uo_out=8'h10 (empty=1, full=0).
- Pointers are log2(DEPTH)+1 bits wide. The extra MSB is a wrap bit.
  - empty = (wptr == rptr).
  - full = (index bits equal) && (wrap bits differ).
  - Both flags are combinational from the registered pointers, so they change in the cycle after the edge that moves a pointer.
- Dividers:
  - wcnt counts 0..WR_DIV-1 and wraps to 0.
  - wr_tick = (wcnt == WR_DIV-1).
  - rcnt and rd_tick work identically with RD_DIV.
  - Both counters run freely after reset, independent of requests and flags.
- Write: on a rising edge where wr_tick && wr_rq && !full:
  - mem[wptr index] <= ui_in[3:0]; wptr += 1.
  - Otherwise the write is dropped silently; no overflow error is produced.
- Read: on a rising edge where rd_tick && rd_rq && !empty:
  - rdata <= mem[rptr index]; rptr += 1.
  - rdata is registered and holds its value between reads.
  - An attempt while empty leaves rdata unchanged.
- Simultaneous write and read on the same edge:
  - Both qualifications use the flags before that edge.
  - When full: the read succeeds and the write is dropped.
  - When empty: the write succeeds and the read is dropped (no fall-through).
  - Otherwise both occur and occupancy is unchanged.
- Wrap-around: the index wraps modulo DEPTH and the wrap bit toggles. Repeated fill/drain cycles must stay correct indefinitely.
- Reset asserted mid-operation: pointers return to 0 immediately, the FIFO reads as empty, and data in flight is discarded.
- Width rule: pointer arithmetic is modulo 2*DEPTH. No saturation logic.

Decomposition:
- Shared package fifo_pkg holds:
  - WIDTH and DEPTH defaults.
  - PTR_W = $clog2(DEPTH)+1.
  - Pin-index constants: WDATA_LSB=0, WR_RQ_BIT=4, RD_RQ_BIT=5, EMPTY_BIT=4, FULL_BIT=5.
- One sub-module is natural: tick_div (parameter DIV; ports clk, rst_n, tick). Instantiate it twice, for write and read.
- The FIFO core (memory, pointers, flags) stays in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, ui_in=8'h3F -> uo_out=8'h10 throughout; no write occurs while in reset.
- Fill: wr_rq=1, rd_rq=0, wdata 0x1,0x2,0x3,0x4 presented on successive write ticks -> empty drops after the first write; full=1 (uo_out[5]) after the 4th; a 5th write of 0x9 is dropped.
- Drain: wr_rq=0, rd_rq=1 -> rdata reads 0x1,0x2,0x3,0x4 on successive read ticks; empty=1 after the 4th; a further read tick leaves rdata=0x4.
- Wrap: 3 full fill/drain passes with values 0x5..0xC -> data order is preserved across pointer wrap; full/empty are correct each pass.
- Concurrent: wr_rq=rd_rq=1 with WR_DIV=2, RD_DIV=3 for 150 write ticks, random data, checked against a reference queue -> no loss, no duplication, and full never coincides with empty.
- Reset mid-stream: 2 entries stored, pulse rst_n low for 1 cycle -> empty=1, full=0, rdata=0; the next write/read returns the newly written value.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and pin mapping for the tiny-tapeout FIFO tile.
// The pointer width carries one extra wrap bit above the index bits.
package fifo_pkg;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 4;
  localparam int WR_DIV = 2;
  localparam int RD_DIV = 3;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // ui_in bit positions
  localparam int WDATA_LSB = 0;
  localparam int WR_RQ_BIT = 4;
  localparam int RD_RQ_BIT = 5;

  // uo_out bit positions
  localparam int EMPTY_BIT = 4;
  localparam int FULL_BIT  = 5;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_flags_t;

endpackage

// File: rtl/tt_um_reemashivva_fifo_tick_div.sv
// Free-running clock-enable divider: tick is high for one clk cycle out of DIV.
// With DIV == 1 the tick is permanently high.
module tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/tt_um_reemashivva_fifo.sv
// Tiny Tapeout tile: 4x4 synchronous FIFO whose write and read sides are paced
// by independent clock-enable ticks; rdata, empty and full appear on uo_out.
module tt_um_reemashivva_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH  = fifo_pkg::WIDTH,
  parameter int DEPTH  = fifo_pkg::DEPTH,
  parameter int WR_DIV = fifo_pkg::WR_DIV,
  parameter int RD_DIV = fifo_pkg::RD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic wr_tick;
  logic rd_tick;

  tick_div #(.DIV(WR_DIV)) u_wr_div (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (wr_tick)
  );

  tick_div #(.DIV(RD_DIV)) u_rd_div (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (rd_tick)
  );

  logic [WIDTH-1:0] wdata;
  logic             wr_rq;
  logic             rd_rq;

  assign wdata = ui_in[WDATA_LSB +: WIDTH];
  assign wr_rq = ui_in[WR_RQ_BIT];
  assign rd_rq = ui_in[RD_RQ_BIT];

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  fifo_flags_t flags;
  logic        do_wr;
  logic        do_rd;

  // Flags come from the registered pointers, so both request qualifications
  // on an edge see the occupancy from before that edge.
  always_comb begin
    flags.empty = (wptr_q == rptr_q);
    flags.full  = (wptr_q[IW-1:0] == rptr_q[IW-1:0]) && (wptr_q[IW] != rptr_q[IW]);
  end

  always_comb begin
    do_wr   = wr_tick && wr_rq && !flags.full;
    do_rd   = rd_tick && rd_rq && !flags.empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rdata_d = rdata_q;
    if (do_wr) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (do_rd) begin
      rptr_d  = rptr_q + PW'(1);
      rdata_d = mem_q[rptr_q[IW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wptr_q[IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    uo_out                       = '0;
    uo_out[WDATA_LSB +: WIDTH]   = rdata_q;
    uo_out[EMPTY_BIT]            = flags.empty;
    uo_out[FULL_BIT]             = flags.full;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

  logic unused_pins;
  assign unused_pins = &{1'b0, ena, uio_in, ui_in[7:6]};

endmodule

// File: tb/tb_tt_um_reemashivva_fifo.sv
// Directed bench for the FIFO tile: a queue-based reference model with its own
// divider counters predicts uo_out after every clock edge.
module tb_tt_um_reemashivva_fifo;

  localparam int WR_DIV = 2;
  localparam int RD_DIV = 3;
  localparam int DEPTH  = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_reemashivva_fifo dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard state
  logic [3:0] exp_q[$];
  logic [3:0] m_rdata;
  int         m_wcnt;
  int         m_rcnt;
  bit         last_wt;
  bit         last_rt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_uo();
    logic full, empty;
    empty = (exp_q.size() == 0);
    full  = (exp_q.size() == DEPTH);
    return {2'b00, full, empty, m_rdata};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_rdata = 4'h0;
    m_wcnt  = 0;
    m_rcnt  = 0;
  endtask

  // one clock edge: predict, advance, then compare away from the edge
  task automatic step();
    bit wt, rt, dw, dr;
    wt = (m_wcnt == WR_DIV - 1);
    rt = (m_rcnt == RD_DIV - 1);
    dw = wt && ui_in[4] && (exp_q.size() < DEPTH);
    dr = rt && ui_in[5] && (exp_q.size() > 0);
    if (dr) m_rdata = exp_q.pop_front();
    if (dw) exp_q.push_back(ui_in[3:0]);
    m_wcnt  = wt ? 0 : m_wcnt + 1;
    m_rcnt  = rt ? 0 : m_rcnt + 1;
    last_wt = wt;
    last_rt = rt;
    @(posedge clk);
    #1;
    chk("uo_out", uo_out, exp_uo());
    chk("full_and_empty", {7'b0, uo_out[4] & uo_out[5]}, 8'h00);
  endtask

  // driver: hold a write request until one write tick has been consumed
  task automatic do_wr(input logic [3:0] d);
    bit done;
    done = 1'b0;
    ui_in[3:0] = d;
    ui_in[4]   = 1'b1;
    for (int i = 0; i < 2 * WR_DIV + 2 && !done; i++) begin
      step();
      done = last_wt;
    end
    ui_in[4] = 1'b0;
    chk("wr_tick_timeout", {7'b0, done}, 8'h01);
  endtask

  task automatic do_rd();
    bit done;
    done = 1'b0;
    ui_in[5] = 1'b1;
    for (int i = 0; i < 2 * RD_DIV + 2 && !done; i++) begin
      step();
      done = last_rt;
    end
    ui_in[5] = 1'b0;
    chk("rd_tick_timeout", {7'b0, done}, 8'h01);
  endtask

  initial begin
    int wticks;
    int guard;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h3F;
    rst_n  = 1'b0;
    model_reset();
    #1;
    chk("reset_now", uo_out, 8'h10);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset_hold", uo_out, 8'h10);
    end
    chk("uio_out", uio_out, 8'h00);
    chk("uio_oe", uio_oe, 8'h00);
    @(negedge clk);
    ui_in = 8'h00;
    rst_n = 1'b1;
    step();

    // fill, then an overflow attempt
    do_wr(4'h1);
    chk("empty_after_first", {7'b0, uo_out[4]}, 8'h00);
    do_wr(4'h2);
    do_wr(4'h3);
    do_wr(4'h4);
    chk("full_after_fourth", {7'b0, uo_out[5]}, 8'h01);
    do_wr(4'h9);
    chk("overflow_dropped", uo_out, 8'h20);

    // drain, then an underflow attempt
    for (int i = 0; i < 4; i++) do_rd();
    chk("drained", uo_out, 8'h14);
    do_rd();
    chk("underflow_hold", uo_out, 8'h14);

    // repeated fill/drain across pointer wrap
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) do_wr(4'(5 + ((p * 4 + i) % 8)));
      chk("wrap_full", {7'b0, uo_out[5]}, 8'h01);
      for (int i = 0; i < 4; i++) do_rd();
      chk("wrap_empty", {7'b0, uo_out[4]}, 8'h01);
    end

    // concurrent producer and consumer with random data
    ui_in[4] = 1'b1;
    ui_in[5] = 1'b1;
    wticks = 0;
    guard  = 0;
    while (wticks < 150 && guard < 2000) begin
      ui_in[3:0] = 4'($urandom_range(0, 15));
      step();
      if (last_wt) wticks++;
      guard++;
    end
    chk("concurrent_budget", {7'b0, wticks >= 150}, 8'h01);
    ui_in[4] = 1'b0;
    repeat (4 * RD_DIV + 2) step();
    chk("concurrent_drained", {7'b0, uo_out[4]}, 8'h01);
    ui_in = 8'h00;

    // reset in the middle of a stream
    do_wr(4'hA);
    do_wr(4'hB);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_now", uo_out, 8'h10);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_after", uo_out, 8'h10);
    do_wr(4'h6);
    do_rd();
    chk("post_reset_data", uo_out, 8'h16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
